pulse_delay_bank: RTL and testbench

//  Multi-channel programmable trigger-to-pulse delay generator. Generalises the

---
 rtl/pulse_delay_bank.sv | 135 +++++++++++++
 tb/tb_pulse_delay_bank.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/pulse_delay_bank.sv
// Multi-channel trigger-to-pulse delay generator. Each channel latches its delay
// and pulse length on a trigger rising edge and emits a delayed registered pulse.

module pdb_lane #(
  parameter int CNT_W   = 8,
  parameter int PULSE_W = 4
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_trig,
  input  logic [CNT_W-1:0]   i_delay,
  input  logic [PULSE_W-1:0] i_pulse_len,
  input  logic               i_retrigger,
  input  logic               i_overrun_clr,
  output logic               o_out_pulse,
  output logic               o_busy,
  output logic               o_overrun
);
  typedef enum logic [1:0] {IDLE, WAIT, PULSE} state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [PULSE_W-1:0] r_pcnt;
  logic               r_hist, r_edge, r_eb, r_rt;
  logic [CNT_W-1:0]   r_d;
  logic [PULSE_W-1:0] r_l;
  logic               r_out, r_busy, r_ovr;
  logic               w_edge, w_start, w_drop;
  logic [PULSE_W-1:0] w_len;

  assign w_edge  = i_trig & ~r_hist;
  // Edges are staged one cycle; r_eb remembers whether the channel was busy
  // when the edge arrived, so an edge in the final pulse cycle still counts.
  assign w_start = r_edge & (~r_eb | r_rt);
  assign w_drop  = r_edge & r_eb & ~r_rt;
  assign w_len   = (r_l == '0) ? PULSE_W'(1) : r_l;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_pcnt  <= '0;
      r_hist  <= i_trig;
      r_edge  <= 1'b0;
      r_eb    <= 1'b0;
      r_rt    <= 1'b0;
      r_d     <= '0;
      r_l     <= '0;
      r_out   <= 1'b0;
      r_busy  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_hist <= i_trig;
      r_edge <= w_edge;
      if (w_edge) begin
        r_d  <= i_delay;
        r_l  <= i_pulse_len;
        r_rt <= i_retrigger;
        r_eb <= (r_state != IDLE);
      end
      if (w_start) begin
        r_pcnt <= w_len;
        r_busy <= 1'b1;
        if (r_d == '0) begin
          r_state <= PULSE;
          r_cnt   <= '0;
          r_out   <= 1'b1;
        end else begin
          r_state <= WAIT;
          r_cnt   <= r_d;
          r_out   <= 1'b0;
        end
      end else begin
        case (r_state)
          WAIT:
            if (r_cnt == CNT_W'(1)) begin
              r_state <= PULSE;
              r_cnt   <= '0;
              r_out   <= 1'b1;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          PULSE:
            if (r_pcnt == PULSE_W'(1)) begin
              r_state <= IDLE;
              r_pcnt  <= '0;
              r_out   <= 1'b0;
              r_busy  <= 1'b0;
            end else begin
              r_pcnt <= r_pcnt - 1'b1;
            end
          default: ;
        endcase
      end
      if (w_drop)             r_ovr <= 1'b1;
      else if (i_overrun_clr) r_ovr <= 1'b0;
    end
  end

  assign o_out_pulse = r_out;
  assign o_busy      = r_busy;
  assign o_overrun   = r_ovr;
endmodule

module pulse_delay_bank #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8,
  parameter int PULSE_W  = 4
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic [CHANNELS-1:0]         i_trig,
  input  logic [CHANNELS*CNT_W-1:0]   i_delay,
  input  logic [CHANNELS*PULSE_W-1:0] i_pulse_len,
  input  logic [CHANNELS-1:0]         i_retrigger,
  input  logic                        i_overrun_clr,
  output logic [CHANNELS-1:0]         o_out_pulse,
  output logic [CHANNELS-1:0]         o_busy,
  output logic [CHANNELS-1:0]         o_overrun
);
  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    pdb_lane #(.CNT_W(CNT_W), .PULSE_W(PULSE_W)) u_lane (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_trig       (i_trig[g]),
      .i_delay      (i_delay[g*CNT_W +: CNT_W]),
      .i_pulse_len  (i_pulse_len[g*PULSE_W +: PULSE_W]),
      .i_retrigger  (i_retrigger[g]),
      .i_overrun_clr(i_overrun_clr),
      .o_out_pulse  (o_out_pulse[g]),
      .o_busy       (o_busy[g]),
      .o_overrun    (o_overrun[g])
    );
  end
endmodule

// File: tb/tb_pulse_delay_bank.sv
// Randomised and directed bench for pulse_delay_bank against a window-based
// reference model: each accepted edge defines busy/pulse cycle windows.

module tb_pulse_delay_bank;
  localparam int CH = 4, CW = 8, PW = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [CH-1:0]     trig, retrig;
  logic [CH*CW-1:0]  dly;
  logic [CH*PW-1:0]  plen;
  logic              oclr;
  logic [CH-1:0]     outp, busy, ovr;

  always #5 clk = ~clk;

  pulse_delay_bank #(.CHANNELS(CH), .CNT_W(CW), .PULSE_W(PW)) dut (
    .i_clk(clk), .i_reset(reset), .i_trig(trig), .i_delay(dly),
    .i_pulse_len(plen), .i_retrigger(retrig), .i_overrun_clr(oclr),
    .o_out_pulse(outp), .o_busy(busy), .o_overrun(ovr)
  );

  int n_tests = 0, n_fail = 0, cyc = 0;

  // model: current and previous acceptance windows per channel
  bit act_c[CH], act_o[CH];
  int kc[CH], dc[CH], lc[CH], ko[CH], dol[CH], lo[CH];
  bit prev[CH], ovr_m[CH], drop[CH];
  logic [CH-1:0] e_out, e_busy, e_ovr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int eff_l(int l);
    return (l == 0) ? 1 : l;
  endfunction

  task automatic model_step();
    cyc++;
    for (int i = 0; i < CH; i++) begin
      int d, l, k, n;
      bit edge_i, was_busy, a;
      n = cyc;
      if (reset) begin
        act_c[i] = 0; act_o[i] = 0; ovr_m[i] = 0; drop[i] = 0;
        prev[i] = trig[i];
      end else begin
        edge_i = trig[i] && !prev[i];
        prev[i] = trig[i];
        if (drop[i]) ovr_m[i] = 1;
        else if (oclr) ovr_m[i] = 0;
        drop[i] = 0;
        if (edge_i) begin
          was_busy = act_c[i] && n >= kc[i] + 1 && n <= kc[i] + dc[i] + eff_l(lc[i]) + 1;
          if (!was_busy || retrig[i]) begin
            act_o[i] = act_c[i]; ko[i] = kc[i]; dol[i] = dc[i]; lo[i] = lc[i];
            act_c[i] = 1; kc[i] = n;
            dc[i] = int'(dly[i*CW +: CW]); lc[i] = int'(plen[i*PW +: PW]);
          end else begin
            drop[i] = 1;
          end
        end
      end
      // a new acceptance at cycle n only takes effect from cycle n+1
      if (act_c[i] && kc[i] < n) begin a = 1; k = kc[i]; d = dc[i]; l = eff_l(lc[i]); end
      else if (act_o[i])          begin a = 1; k = ko[i]; d = dol[i]; l = eff_l(lo[i]); end
      else                        begin a = 0; k = 0; d = 0; l = 1; end
      e_out[i]  = a && n >= k + d + 1 && n <= k + d + l;
      e_busy[i] = a && n >= k + 1 && n <= k + d + l;
      e_ovr[i]  = ovr_m[i];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("out_pulse", 32'(outp), 32'(e_out));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("overrun", 32'(ovr), 32'(e_ovr));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic setch(input int ch, input int d, input int l, input bit rt);
    dly[ch*CW +: CW]  = CW'(d);
    plen[ch*PW +: PW] = PW'(l);
    retrig[ch]        = rt;
  endtask

  task automatic fire(input logic [CH-1:0] m);
    trig = trig | m;
    tick();
    trig = trig & ~m;
    tick();
  endtask

  int hi;

  initial begin
    reset = 1'b1; trig = 4'b1000; retrig = '0; dly = '0; plen = '0; oclr = 1'b0;
    ticks(3);
    chk("reset_out", 32'(outp), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    reset = 1'b0;

    // trig[3] held through reset release must not fire
    setch(3, 2, 2, 0);
    hi = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (outp[3] || busy[3]) hi++; end
    chk("held_no_fire", 32'(hi), 32'd0);
    trig[3] = 1'b0; tick();
    trig[3] = 1'b1;
    hi = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (outp[3]) hi++; end
    trig[3] = 1'b0;
    for (int i = 0; i < 5; i++) begin tick(); if (outp[3]) hi++; end
    chk("held_one_pulse", 32'(hi), 32'd2);

    // long delay, single-cycle pulse
    setch(0, 10, 1, 0);
    hi = 0;
    trig[0] = 1'b1; tick(); trig[0] = 1'b0;
    for (int i = 0; i < 14; i++) begin tick(); if (outp[0]) hi++; end
    chk("d10_pulse_len", 32'(hi), 32'd1);

    // zero delay, L=3 then L=0
    setch(1, 0, 3, 0); fire(4'b0010); ticks(4);
    setch(1, 0, 0, 0); fire(4'b0010); ticks(3);

    // overrun, clear, and clear coinciding with a set
    setch(0, 20, 2, 0);
    fire(4'b0001); ticks(5);
    setch(0, 3, 7, 0);
    fire(4'b0001); ticks(3);
    oclr = 1'b1; tick(); oclr = 1'b0;
    chk("ovr_cleared", 32'(ovr[0]), 32'd0);
    trig[0] = 1'b1; tick(); trig[0] = 1'b0;
    oclr = 1'b1; tick(); oclr = 1'b0;
    chk("ovr_set_wins", 32'(ovr[0]), 32'd1);
    ticks(20);

    // retrigger during pulse
    setch(2, 4, 6, 1);
    fire(4'b0100); ticks(4);
    fire(4'b0100); ticks(18);

    // all channels together, inputs changed mid-wait
    setch(0, 3, 2, 0); setch(1, 7, 2, 0); setch(2, 0, 2, 0); setch(3, 255, 2, 0);
    fire(4'b1111);
    dly = {4{8'd1}}; plen = {4{4'd9}};
    ticks(262);

    // reset mid-wait on ch1 kills the pending pulse
    setch(1, 7, 2, 0);
    fire(4'b0010); tick();
    reset = 1'b1; tick(); reset = 1'b0;
    hi = 0;
    for (int i = 0; i < 12; i++) begin tick(); if (outp[1] || busy[1]) hi++; end
    chk("reset_kills", 32'(hi), 32'd0);

    // randomised traffic
    for (int c = 0; c < 3000; c++) begin
      for (int ch = 0; ch < CH; ch++) begin
        if ($urandom_range(5) == 0) trig[ch] = ~trig[ch];
        dly[ch*CW +: CW]  = ($urandom_range(49) == 0) ? CW'(40) : CW'($urandom_range(12));
        plen[ch*PW +: PW] = PW'($urandom_range(15));
        if ($urandom_range(19) == 0) retrig[ch] = ~retrig[ch];
      end
      oclr  = ($urandom_range(9) == 0);
      reset = ($urandom_range(299) == 0);
      tick();
    end
    reset = 1'b0; oclr = 1'b0; trig = '0;
    ticks(60);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
